// File: rtl/data_memory_port_if.sv
// data_memory_port_if: request/response bundle
// between the memory stage and the data RAM port.
interface data_memory_port_if;
  logic        i_ReqValid;
  logic        o_ReqReady;
  logic        i_WriteEnable;
  logic [31:0] i_Address;
  logic [31:0] i_DataIn;
  logic [2:0]  i_Mode;
  logic        i_RespReady;
  logic        o_RespValid;
  logic [31:0] o_DataOut;
  logic        o_MisalignedAccess;
  logic        o_BadInstruction;
  logic        o_AddressFault;

  modport master (
    output i_ReqValid, i_WriteEnable,
    output i_Address, i_DataIn, i_Mode,
    output i_RespReady,
    input  o_ReqReady, o_RespValid,
    input  o_DataOut, o_MisalignedAccess,
    input  o_BadInstruction, o_AddressFault
  );

  modport slave (
    input  i_ReqValid, i_WriteEnable,
    input  i_Address, i_DataIn, i_Mode,
    input  i_RespReady,
    output o_ReqReady, o_RespValid,
    output o_DataOut, o_MisalignedAccess,
    output o_BadInstruction, o_AddressFault
  );
endinterface

// File: rtl/data_memory_port.sv
// data_memory_port: handshaked byte-lane data RAM
// with fixed response latency and error flags.
module data_memory_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 1
) (
  input logic i_Clock,
  input logic i_Reset_n,
  data_memory_port_if.slave bus
);
  localparam int Words = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    Idle, Wait, Resp
  } state_t;

  state_t state, nextState;
  logic [2:0] count, nextCount;

  logic [31:0] mem [Words];

  logic accept;
  logic badMode, misaligned, addrFault;
  logic anyErr, doWrite;
  logic [ADDR_WIDTH-3:0] wordIdx;
  logic [1:0] offset;
  logic [31:0] readWord;
  logic [7:0] byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic [31:0] writeData;
  logic [3:0] byteEn;

  logic [31:0] dataOut;
  logic misFlag, badFlag, faultFlag;

  assign wordIdx = bus.i_Address[ADDR_WIDTH-1:2];
  assign offset = bus.i_Address[1:0];
  assign accept = bus.i_ReqValid && state == Idle;
  assign addrFault = |bus.i_Address[31:ADDR_WIDTH];
  assign anyErr = badMode | misaligned | addrFault;
  assign doWrite = accept & bus.i_WriteEnable & ~anyErr;
  assign readWord = mem[wordIdx];

  // classify mode legality and alignment
  always_comb begin
    badMode = 1'b0;
    if (bus.i_WriteEnable)
      badMode = bus.i_Mode[2]
        | (bus.i_Mode[1:0] == 2'b11);
    else
      badMode = (bus.i_Mode[1:0] == 2'b11)
        | (bus.i_Mode[2:1] == 2'b11);
    misaligned =
      (bus.i_Mode[1:0] == 2'b01 && offset[0])
      || (bus.i_Mode[1:0] == 2'b10 && offset != 2'b00);
  end

  // select and extend the loaded lane(s)
  always_comb begin
    byteSel = readWord[{offset, 3'b000} +: 8];
    halfSel = offset[1] ? readWord[31:16]
                        : readWord[15:0];
    loadData = '0;
    case (bus.i_Mode)
      3'b000: loadData = {{24{byteSel[7]}}, byteSel};
      3'b001: loadData = {{16{halfSel[15]}}, halfSel};
      3'b010: loadData = readWord;
      3'b100: loadData = {24'd0, byteSel};
      3'b101: loadData = {16'd0, halfSel};
      default: loadData = '0;
    endcase
  end

  // replicate store data and pick byte lanes
  always_comb begin
    writeData = bus.i_DataIn;
    byteEn = 4'b1111;
    case (bus.i_Mode[1:0])
      2'b00: begin
        writeData = {4{bus.i_DataIn[7:0]}};
        byteEn = 4'b0001 << offset;
      end
      2'b01: begin
        writeData = {2{bus.i_DataIn[15:0]}};
        byteEn = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        writeData = bus.i_DataIn;
        byteEn = 4'b1111;
      end
    endcase
  end

  // byte-lane RAM write, contents never reset
  always_ff @(posedge i_Clock) begin
    for (int i = 0; i < 4; i++)
      if (doWrite && byteEn[i])
        mem[wordIdx][i*8 +: 8] <= writeData[i*8 +: 8];
  end

  // state and latency counter registers
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= Idle;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  // next state: idle -> wait -> resp -> idle
  always_comb begin
    nextState = state;
    nextCount = count;
    unique case (state)
      Idle: begin
        if (bus.i_ReqValid) begin
          if (LATENCY > 1) begin
            nextState = Wait;
            nextCount = 3'(LATENCY - 1);
          end else begin
            nextState = Resp;
          end
        end
      end
      Wait: begin
        nextCount = count - 3'd1;
        if (count == 3'd1)
          nextState = Resp;
      end
      Resp: begin
        if (bus.i_RespReady)
          nextState = Idle;
      end
      default: nextState = Idle;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.o_ReqReady = (state == Idle);
    bus.o_RespValid = (state == Resp);
  end

  // response payload captured at accept
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      dataOut <= '0;
      badFlag <= 1'b0;
      misFlag <= 1'b0;
      faultFlag <= 1'b0;
    end else if (accept) begin
      dataOut <= (anyErr || bus.i_WriteEnable)
        ? '0 : loadData;
      badFlag <= badMode;
      misFlag <= ~badMode & misaligned;
      faultFlag <= ~badMode & ~misaligned & addrFault;
    end
  end

  assign bus.o_DataOut = dataOut;
  assign bus.o_BadInstruction = badFlag;
  assign bus.o_MisalignedAccess = misFlag;
  assign bus.o_AddressFault = faultFlag;
endmodule

// File: tb/tb_data_memory_port.sv
// tb_data_memory_port: two ports (latency 1 and 4)
// checked each cycle against a byte-level model.
module tb_data_memory_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] reqValid = '0;
  logic [1:0] we = '0;
  logic [1:0] respReady = '0;
  logic [31:0] addr [2];
  logic [31:0] din [2];
  logic [2:0] mode [2];
  logic [1:0] reqReady, respValid;
  logic [31:0] dout [2];
  logic [2:0] flg [2];

  int checks = 0;
  int errors = 0;

  data_memory_port_if ifA ();
  data_memory_port_if ifB ();

  assign ifA.i_ReqValid = reqValid[0];
  assign ifA.i_WriteEnable = we[0];
  assign ifA.i_Address = addr[0];
  assign ifA.i_DataIn = din[0];
  assign ifA.i_Mode = mode[0];
  assign ifA.i_RespReady = respReady[0];
  assign reqReady[0] = ifA.o_ReqReady;
  assign respValid[0] = ifA.o_RespValid;
  assign dout[0] = ifA.o_DataOut;
  assign flg[0] = {ifA.o_BadInstruction,
    ifA.o_MisalignedAccess, ifA.o_AddressFault};

  assign ifB.i_ReqValid = reqValid[1];
  assign ifB.i_WriteEnable = we[1];
  assign ifB.i_Address = addr[1];
  assign ifB.i_DataIn = din[1];
  assign ifB.i_Mode = mode[1];
  assign ifB.i_RespReady = respReady[1];
  assign reqReady[1] = ifB.o_ReqReady;
  assign respValid[1] = ifB.o_RespValid;
  assign dout[1] = ifB.o_DataOut;
  assign flg[1] = {ifB.o_BadInstruction,
    ifB.o_MisalignedAccess, ifB.o_AddressFault};

  data_memory_port #(
    .ADDR_WIDTH(16), .LATENCY(1)
  ) dut0 (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .bus(ifA.slave)
  );

  data_memory_port #(
    .ADDR_WIDTH(16), .LATENCY(4)
  ) dut1 (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .bus(ifB.slave)
  );

  always #5 clk = ~clk;

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string nm,
      input logic [31:0] act,
      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
        nm, act, exp);
    end
  endtask

  // behavioural model: byte memory plus busy tracking
  logic [7:0] mm [int];
  int cyc = 0;
  bit busy [2] = '{0, 0};
  int acc [2] = '{0, 0};
  logic [31:0] eData [2];
  logic [2:0] eFlg [2];
  bit eKnown [2];

  function automatic int key(input int d,
      input logic [31:0] a);
    return (d << 24) | int'(a[23:0]);
  endfunction

  task automatic modelAccept(input int d);
    int n;
    bit bad, mis, flt;
    logic [31:0] v;
    logic [31:0] a;
    logic [2:0] m;
    a = addr[d];
    m = mode[d];
    n = 1 << m[1:0];
    if (we[d])
      bad = (m > 3'd2);
    else
      bad = !(m inside {3'd0, 3'd1, 3'd2,
                        3'd4, 3'd5});
    mis = (a % n) != 0;
    flt = a >= 32'h0001_0000;
    eFlg[d] = bad ? 3'b100 : mis ? 3'b010
            : flt ? 3'b001 : 3'b000;
    eData[d] = '0;
    eKnown[d] = 1'b1;
    if (eFlg[d] == 3'b000) begin
      if (we[d]) begin
        for (int i = 0; i < n; i++)
          mm[key(d, a + i)] = 8'(din[d] >> (8 * i));
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) begin
          if (!mm.exists(key(d, a + i)))
            eKnown[d] = 1'b0;
          else
            v = v | (32'(mm[key(d, a + i)]) << (8 * i));
        end
        if (!m[2] && n < 4 && v[8*n-1])
          v = v - (32'd1 << (8 * n));
        eData[d] = v;
      end
    end
    busy[d] = 1'b1;
    acc[d] = cyc;
  endtask

  initial forever begin
    bit vNow [2];
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      busy[0] = 1'b0;
      busy[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++)
        vNow[d] = busy[d]
          && cyc >= acc[d] + latOf(d) - 1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) begin
          if (vNow[d] && respReady[d])
            busy[d] = 1'b0;
        end else if (reqValid[d]) begin
          modelAccept(d);
        end
      end
    end
  end

  initial forever begin
    bit ev;
    @(negedge clk);
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        ev = busy[d]
          && cyc >= acc[d] + latOf(d) - 1;
        chk($sformatf("ready%0d", d),
          32'(reqReady[d]), 32'(!busy[d]));
        chk($sformatf("valid%0d", d),
          32'(respValid[d]), 32'(ev));
        if (ev) begin
          if (eKnown[d])
            chk($sformatf("data%0d", d),
              dout[d], eData[d]);
          chk($sformatf("flags%0d", d),
            32'(flg[d]), 32'(eFlg[d]));
        end
      end
    end
  end

  task automatic xact(input int d, input bit w,
      input logic [31:0] a,
      input logic [31:0] dd,
      input logic [2:0] m,
      input int stall,
      output logic [31:0] rd,
      output logic [2:0] rf,
      output int lat);
    int n;
    int c0;
    reqValid[d] = 1'b1;
    we[d] = w;
    addr[d] = a;
    din[d] = dd;
    mode[d] = m;
    respReady[d] = 1'b0;
    n = 0;
    while (!reqReady[d] && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50)
      chk("acceptTimeout", 32'(reqReady[d]), 32'd1);
    @(posedge clk); #2;
    c0 = cyc;
    we[d] = 1'($urandom);
    addr[d] = $urandom;
    din[d] = $urandom;
    mode[d] = 3'($urandom);
    n = 0;
    while (!respValid[d] && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50)
      chk("respTimeout", 32'(respValid[d]), 32'd1);
    lat = cyc - c0 + 1;
    rd = dout[d];
    rf = flg[d];
    repeat (stall) begin
      @(posedge clk); #2;
    end
    reqValid[d] = 1'b0;
    respReady[d] = 1'b1;
    @(posedge clk); #2;
    respReady[d] = 1'b0;
  endtask

  task automatic chkReset(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "Ready"}, 32'(reqReady[d]), 32'd1);
      chk({nm, "Valid"}, 32'(respValid[d]), 32'd0);
      chk({nm, "Data"}, dout[d], 32'd0);
      chk({nm, "Flags"}, 32'(flg[d]), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [2:0] rf;
    int lat;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0;
      din[d] = '0;
      mode[d] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    chkReset("rst");
    rst_n = 1'b1;
    @(posedge clk); #2;

    xact(0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0,
      rd, rf, lat);
    chk("swFlags", 32'(rf), 32'd0);
    chk("swLat", 32'(lat), 32'd1);
    xact(0, 0, 32'h100, 32'h0, 3'b010, 0,
      rd, rf, lat);
    chk("lwData", rd, 32'hDEADBEEF);
    chk("lwFlags", 32'(rf), 32'd0);
    chk("lwLat", 32'(lat), 32'd1);

    xact(0, 1, 32'h200, 32'h80FF7F01, 3'b010, 0,
      rd, rf, lat);
    xact(0, 0, 32'h202, 32'h0, 3'b000, 0,
      rd, rf, lat);
    chk("lb202", rd, 32'hFFFFFFFF);
    xact(0, 0, 32'h203, 32'h0, 3'b100, 0,
      rd, rf, lat);
    chk("lbu203", rd, 32'h00000080);
    xact(0, 0, 32'h202, 32'h0, 3'b001, 0,
      rd, rf, lat);
    chk("lh202", rd, 32'hFFFF80FF);
    xact(0, 0, 32'h200, 32'h0, 3'b101, 0,
      rd, rf, lat);
    chk("lhu200", rd, 32'h00007F01);
    xact(0, 1, 32'h201, 32'h000000AA, 3'b000, 0,
      rd, rf, lat);
    xact(0, 0, 32'h200, 32'h0, 3'b010, 0,
      rd, rf, lat);
    chk("sbMerge", rd, 32'h80FFAA01);

    xact(0, 0, 32'h102, 32'h0, 3'b010, 0,
      rd, rf, lat);
    chk("lwMisFlags", 32'(rf), 32'b010);
    chk("lwMisData", rd, 32'd0);
    xact(0, 1, 32'h101, 32'h1234, 3'b001, 0,
      rd, rf, lat);
    chk("shMisFlags", 32'(rf), 32'b010);
    xact(0, 0, 32'h100, 32'h0, 3'b010, 0,
      rd, rf, lat);
    chk("shMisKeep", rd, 32'hDEADBEEF);
    xact(0, 1, 32'h300, 32'h55, 3'b100, 0,
      rd, rf, lat);
    chk("stBadMode", 32'(rf), 32'b100);
    xact(0, 0, 32'h0001_0000, 32'h0, 3'b010, 0,
      rd, rf, lat);
    chk("lwFault", 32'(rf), 32'b001);
    chk("lwFaultData", rd, 32'd0);
    xact(0, 0, 32'h0001_0001, 32'h0, 3'b011, 0,
      rd, rf, lat);
    chk("badOnly", 32'(rf), 32'b100);

    xact(1, 1, 32'h40, 32'h12345678, 3'b010, 0,
      rd, rf, lat);
    chk("l4SwLat", 32'(lat), 32'd4);
    xact(1, 0, 32'h40, 32'h0, 3'b010, 3,
      rd, rf, lat);
    chk("l4Data", rd, 32'h12345678);
    chk("l4Lat", 32'(lat), 32'd4);
    xact(1, 0, 32'h42, 32'h0, 3'b101, 0,
      rd, rf, lat);
    chk("l4Lhu", rd, 32'h00001234);

    xact(1, 1, 32'h44, 32'hCAFEF00D, 3'b010, 0,
      rd, rf, lat);
    reqValid[1] = 1'b1;
    we[1] = 1'b0;
    addr[1] = 32'h44;
    mode[1] = 3'b010;
    @(posedge clk); #2;
    reqValid[1] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chkReset("midRst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    xact(1, 0, 32'h44, 32'h0, 3'b010, 0,
      rd, rf, lat);
    chk("afterRst", rd, 32'hCAFEF00D);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        xact(d, 1, 32'(i * 4), $urandom, 3'b010, 0,
          rd, rf, lat);
      repeat (120) begin
        if ($urandom_range(0, 7) == 0)
          a = 32'h0001_0000 | $urandom_range(0, 63);
        else
          a = $urandom_range(0, 63);
        xact(d, 1'($urandom_range(0, 1)), a,
          $urandom, 3'($urandom_range(0, 7)),
          $urandom_range(0, 3), rd, rf, lat);
      end
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory_port.md
# data_memory_port

Parametrised, handshaked successor to the combinational split data memory. It owns a byte-lane RAM of 2^ADDR_WIDTH bytes and accepts one load or store request at a time over a valid/ready interface. Reads are synchronous, and the response arrives after a configurable latency. Every access returns a response carrying load data or error status: misaligned, invalid mode, or out-of-range address. It sits between the core's memory stage and the data RAM, and lets the pipeline stall on wait states.

## Interface
- ADDR_WIDTH, 16: byte-address bits decoded; RAM holds 2^(ADDR_WIDTH-2) 32-bit words; legal 3..24
- LATENCY, 1: cycles from request acceptance to o_RespValid; legal 1..8
- i_Clock  in  1  single clock, rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_ReqValid  in  1  request present
- o_ReqReady  out  1  block can accept a request
- i_WriteEnable  in  1  1 = store, 0 = load; sampled with request
- i_Address  in  32  byte address
- i_DataIn  in  32  store data, right-aligned
- i_Mode  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- i_RespReady  in  1  consumer takes response
- o_RespValid  out  1  response present
- o_DataOut  out  32  load result, extended per mode; 0 for stores and errored accesses
- o_MisalignedAccess  out  1  response flag
- o_BadInstruction  out  1  response flag: mode illegal for direction
- o_AddressFault  out  1  response flag: i_Address[31:ADDR_WIDTH] != 0

## Operation
- FSM states are IDLE, WAIT and RESP. o_ReqReady = (state == IDLE).
- IDLE: on i_ReqValid & o_ReqReady, the request is accepted.
  - Classify the request with priority bad mode > misaligned > address fault. At most one flag is set.
  - Halfword accesses require addr[0] = 0. Word accesses require addr[1:0] = 0. Byte accesses are always aligned.
  - Error-free store: write the byte lanes at the accept edge.
    - SB: lane = addr[1:0].
    - SH: lanes {1,0} or {3,2}.
    - SW: all lanes.
    - Data comes from i_DataIn low bits.
  - Error-free load: read the word at the accept edge into a registered holding word, then extract and sign/zero-extend per mode and addr[1:0].
  - Errored access: no RAM write; o_DataOut = 0.
  - Next state is WAIT with counter = LATENCY-1 if LATENCY > 1; otherwise RESP.
- WAIT: decrement the counter each cycle. At 0, go to RESP.
- RESP: o_RespValid = 1. o_DataOut and the flags hold stable until i_RespReady is sampled high, then go to IDLE.
  - o_DataOut and the flags keep their last value afterwards until the next response is loaded.
- Only one request is outstanding at a time. There is no pipelining.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, o_ReqReady = 1, o_RespValid = 0, o_DataOut = 0, all flags 0, counter 0. Reset asserts asynchronously and releases synchronously.
- Accept at edge N → o_RespValid is high from edge N+LATENCY. LATENCY=1 gives a response in the cycle immediately after acceptance.
- Response consumed at edge M (o_RespValid & i_RespReady) → o_ReqReady high after edge M. Next accept is possible at edge M+1.
- Minimum request spacing is LATENCY+1 cycles.
- i_RespReady held high means the response lasts exactly one cycle.
- The request payload is ignored when o_ReqReady = 0. i_ReqValid may be held high across busy cycles without effect.
- Store write visibility: a load accepted at any later edge returns the new data.
- Reset mid-operation:
  - A pending response is discarded and outputs return to reset values.
  - A store whose accept edge preceded reset assertion remains written.
- The o_DataOut extension is computed from the holding word at the accept edge, so later stores cannot affect an in-flight response.

## Test plan
- Word round trip, LATENCY=1: SW 0xDEADBEEF @0x0100, then LW @0x0100 → o_DataOut = 0xDEADBEEF, o_RespValid exactly 1 cycle after each accept, no flags.
- Byte/half extension:
  - Stimulus: SW 0x80FF7F01 @0x0200.
  - LB @0x0202 → 0xFFFFFFFF. LBU @0x0203 → 0x00000080. LH @0x0202 → 0xFFFF80FF. LHU @0x0200 → 0x00007F01.
  - SB 0xAA @0x0201 then LW @0x0200 → 0x80FFAA01.
- Errors:
  - LW @0x0102 → o_MisalignedAccess = 1, data 0.
  - SH @0x0101 → o_MisalignedAccess = 1; a follow-up LW @0x0100 proves the word is unchanged.
  - Store mode 100 → o_BadInstruction = 1.
  - LW @0x00010000 with ADDR_WIDTH=16 → o_AddressFault = 1.
  - Mode 011 at addr 0x00010001 → only o_BadInstruction.
- Latency/backpressure, LATENCY=4:
  - Accept at edge N → o_RespValid rises at N+4.
  - With i_RespReady low for 3 cycles, o_ReqReady stays 0 and the response holds stable. i_ReqValid held high during busy cycles is not accepted.
  - When i_RespReady rises, the next request is accepted one cycle later.
- Reset mid-operation: assert i_Reset_n low during WAIT of a LW → all outputs 0 and o_ReqReady = 1 immediately (asynchronously). A store accepted before reset reads back its data after reset.
